// File: rtl/serial_bcd_adder_if.sv
// Bundled request/response signals for the digit-serial BCD adder.
// Handshake: start is sampled only while the adder is idle; busy is high while
// digits are being added; done pulses for one cycle when sum/cout/err are valid,
// and those results hold until the next accepted start. There is no backpressure.
interface serial_bcd_adder_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/serial_bcd_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, least significant first.
// Operands are captured on start so the request bus may change freely during the add.
module serial_bcd_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_bcd_adder_if.slave   bus,
  output logic [1:0]          dbg_state
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] opa_q, opa_d;
  logic [4*DIGITS-1:0] opb_q, opb_d;
  logic [4*DIGITS-1:0] sum_q, sum_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                carry_q, carry_d;
  logic                cout_q, cout_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [IW+1:0]       bit_pos;
  logic [3:0]          dig_a;
  logic [3:0]          dig_b;
  logic [4:0]          raw;
  logic [4:0]          adj;
  logic                k;
  logic [3:0]          digit;
  logic                bad_digit;

  assign bit_pos = {idx_q, 2'b00};
  assign dig_a   = opa_q[bit_pos +: 4];
  assign dig_b   = opb_q[bit_pos +: 4];
  assign raw     = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, carry_q};
  assign adj     = raw + 5'd6;
  assign k       = (raw > 5'd9);
  assign digit   = k ? adj[3:0] : raw[3:0];

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((bus.a[4*i +: 4] > 4'd9) || (bus.b[4*i +: 4] > 4'd9)) bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          opa_d   = bus.a;
          opb_d   = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = bad_digit;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[bit_pos +: 4] = digit;
        carry_d = k;
        if (idx_q == LAST_IDX) begin
          cout_d  = k;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_bcd_adder.sv
// Directed bench for serial_bcd_adder: a 4-digit and a 1-digit instance, table-driven
// vectors plus hand-written sequences for overlapping start and mid-add reset.
module tb_serial_bcd_adder;

  logic clk;
  logic rst_n;
  logic [1:0] dbg4, dbg1;
  logic sel;
  int checks;
  int errors;

  serial_bcd_adder_if #(.DIGITS(4)) if4 ();
  serial_bcd_adder_if #(.DIGITS(1)) if1 ();

  serial_bcd_adder #(.DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave), .dbg_state(dbg4));
  serial_bcd_adder #(.DIGITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave), .dbg_state(dbg1));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        cur_busy, cur_done, cur_cout, cur_err;
  logic [15:0] cur_sum;
  assign cur_busy = sel ? if1.busy : if4.busy;
  assign cur_done = sel ? if1.done : if4.done;
  assign cur_cout = sel ? if1.cout : if4.cout;
  assign cur_err  = sel ? if1.err  : if4.err;
  assign cur_sum  = sel ? {12'h000, if1.sum} : if4.sum;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } vec_t;

  vec_t v4[8];
  vec_t v1[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [15:0] a, input logic [15:0] b, input logic cin);
    if (sel) begin
      if1.start = st; if1.a = a[3:0]; if1.b = b[3:0]; if1.cin = cin;
    end else begin
      if4.start = st; if4.a = a; if4.b = b; if4.cin = cin;
    end
  endtask

  // Issue one add and watch a fixed window; latency is the edge count after E0 at which done is seen.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input bit inject,
                        output logic [15:0] s, output logic co, output logic er,
                        output int busy_n, output int lat, output int done_n);
    @(negedge clk);
    drive(1'b1, a, b, cin);
    @(posedge clk); #1;
    drive(1'b0, a, b, cin);
    busy_n = 0; lat = -1; done_n = 0; s = '0; co = 1'b0; er = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (inject && c == 1) drive(1'b1, 16'h1111, 16'h2222, 1'b1);
      if (inject && c == 2) drive(1'b0, 16'h3333, 16'h4444, 1'b1);
      if (cur_busy) busy_n++;
      if (cur_done) begin
        done_n++;
        if (lat < 0) begin
          lat = c; s = cur_sum; co = cur_cout; er = cur_err;
        end
      end
      @(posedge clk); #1;
    end
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic run_vec(input string tag, input vec_t v, input int digits, input bit inject);
    logic [15:0] s; logic co, er; int bn, lat, dn;
    run_op(v.a, v.b, v.cin, inject, s, co, er, bn, lat, dn);
    check({tag, " sum"}, s, v.sum);
    check({tag, " cout"}, co, v.cout);
    check({tag, " err"}, er, v.err);
    check({tag, " busy_cycles"}, bn, digits);
    check({tag, " latency"}, lat, digits);
    check({tag, " done_pulses"}, dn, 1);
    check({tag, " sum_held"}, cur_sum, v.sum);
  endtask

  initial begin
    logic [15:0] s; logic co, er; int bn, lat, dn;
    checks = 0; errors = 0; sel = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;

    v4[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    v4[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    v4[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    // digit 1 of a is 0xA: raw 10 gives 0 and a carry that lands in digit 2
    v4[3] = '{16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1};
    v4[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    v4[5] = '{16'h0000, 16'hF000, 1'b0, 16'h5000, 1'b1, 1'b1};
    v4[6] = '{16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0};
    v4[7] = '{16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0};

    v1[0] = '{16'h0008, 16'h0007, 1'b1, 16'h0006, 1'b1, 1'b0};
    v1[1] = '{16'h0004, 16'h0005, 1'b0, 16'h0009, 1'b0, 1'b0};
    v1[2] = '{16'h000A, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0;
    #12;
    check("reset busy", if4.busy, 1'b0);
    check("reset done", if4.done, 1'b0);
    check("reset sum", if4.sum, 16'h0000);
    check("reset cout", if4.cout, 1'b0);
    check("reset err", if4.err, 1'b0);
    check("reset state", dbg4, 2'd0);
    check("reset d1 sum", if1.sum, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec($sformatf("d4 vec%0d", i), v4[i], 4, 1'b0);

    // start and operand changes during ADD must not disturb the running add
    run_vec("d4 overlap", v4[0], 4, 1'b1);
    run_vec("d4 after_overlap", v4[6], 4, 1'b0);

    // reset during the second ADD cycle
    @(negedge clk);
    if4.start = 1'b1; if4.a = 16'h12A4; if4.b = 16'h5678; if4.cin = 1'b0;
    @(posedge clk); #1;
    if4.start = 1'b0;
    @(posedge clk); #1;
    check("midrst partial sum", if4.sum, 16'h0002);
    check("midrst err before", if4.err, 1'b1);
    check("midrst busy before", if4.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", if4.busy, 1'b0);
    check("midrst done", if4.done, 1'b0);
    check("midrst sum", if4.sum, 16'h0000);
    check("midrst cout", if4.cout, 1'b0);
    check("midrst err", if4.err, 1'b0);
    check("midrst state", dbg4, 2'd0);
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (if4.done) dn++;
    end
    check("midrst no_done", dn, 0);
    check("midrst sum_after", if4.sum, 16'h0000);
    rst_n = 1'b1;
    run_op(16'h0005, 16'h0005, 1'b0, 1'b0, s, co, er, bn, lat, dn);
    check("post_rst sum", s, 16'h0010);
    check("post_rst cout", co, 1'b0);
    check("post_rst err", er, 1'b0);
    check("post_rst latency", lat, 4);

    sel = 1'b1;
    for (int i = 0; i < 3; i++) run_vec($sformatf("d1 vec%0d", i), v1[i], 1, 1'b0);
    sel = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
